token_scheduler: RTL
====================

# token_scheduler

Serial token scheduler that sits downstream of the token-reduction stages and shares the thinned token stream between several consumer lanes. Every R-th incoming `1` token on the serial input passes; passed tokens are dealt round-robin to enabled lanes. The ratio R is loaded through a valid/ready configuration handshake. R = 2 reproduces the halve-by-two behaviour, delivered one cycle later.

## Interface
- `N_LANES`, 4: number of consumer lanes (2..8).
- `RATIO_W`, 4: width of the ratio field.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `a`  in  1  serial token input; one token per cycle in which `a`=1.
- `cfg_valid`  in  1  new ratio offered.
- `cfg_ratio`  in  RATIO_W  ratio R; 0 = mute, 1 = pass all, k = pass every k-th token.
- `cfg_ready`  out  1  ratio can be accepted this cycle.
- `lane_en`  in  N_LANES  per-lane enable, sampled every cycle.
- `b`  out  N_LANES  one-hot-or-zero token output, registered.
- `drop`  out  1  registered pulse: a passing token found no enabled lane.

## Operation
- FSM states: IDLE, LOAD, RUN.
  - IDLE: entered on reset. Tokens are ignored. `cfg_ready`=1.
  - LOAD: lasts exactly 1 cycle. Token counter cleared, ratio register written. Tokens on `a` are ignored. `cfg_ready`=0.
  - RUN: tokens are counted and scheduled. `cfg_ready`=1.
- Handshake and transitions:
  - Accept = `cfg_valid & cfg_ready`, in IDLE or RUN.
  - Accept moves the FSM to LOAD. LOAD always moves to RUN.
  - `cfg_ratio` is captured in the accept cycle.
- Token counter:
  - RATIO_W bits, counts `a`=1 cycles in RUN.
  - A token passes when count == R-1. The counter then returns to 0; otherwise it increments.
  - R=0: no token passes, the counter holds at 0, and `drop` stays 0.
  - R=1: every token passes.
- Round-robin pointer: `last` is the lane index of the most recent grant; reset value N_LANES-1.
  - A passing token is granted to the first enabled lane scanning `last`+1, `last`+2, … modulo N_LANES, using the `lane_en` value of the same cycle.
  - The grant sets that lane's bit in `b` on the next cycle and updates `last`.
  - No enabled lane: `drop`=1 next cycle, `b`=0, `last` unchanged, and the counter still wraps to 0.
- Simultaneous events:
  - Accept and `a`=1 in RUN: the token is processed with the old R. The counter clears in LOAD.
  - `lane_en` change and passing token in the same cycle: the new `lane_en` value applies.
  - `cfg_valid` held high across LOAD: accepted again at the first RUN cycle.
- Reset mid-operation: asynchronous. State goes to IDLE, counter 0, R 0, `last` N_LANES-1, `b`=0, `drop`=0 immediately. A token in flight is lost.

## Timing
- Reset values:
  - `b`=0, `drop`=0.
  - `cfg_ready`=1, since IDLE has ready high.
  - Stats counters 0.
- Latency:
  - `a` to `b`/`drop`: 1 cycle, registered.
  - Config accept to first counted token: 2 cycles (accept cycle, then LOAD).
- Throughput: one token per cycle sustained. Two back-to-back passing tokens (R=1) go to different enabled lanes when at least two are enabled.
- `cfg_ready` is a combinational decode of the state register only, never of `cfg_valid`.

## Configuration
- Macro `TOKEN_SCHEDULER_STATS_EN`.
- Defined: adds outputs `pass_cnt` and `drop_cnt`, 16 bits each.
  - `pass_cnt` counts `b` pulses; `drop_cnt` counts `drop` pulses.
  - Both saturate at 16'hFFFF and clear on reset and on LOAD.
  - Counts update in the same cycle as the `b`/`drop` pulse they count.
- Undefined: ports and logic absent. The remaining behaviour is identical.

## Structure
- Package `token_sched_pkg`:
  - state enum `sched_state_t` (IDLE, LOAD, RUN);
  - `STATS_W` = 16;
  - `RATIO_MUTE` = 0.
- Sub-module `token_rr_select`: purely combinational.
  - Inputs: `last`, `lane_en`.
  - Outputs: one-hot `grant` and a `none` flag.
  - Instantiated once. The FSM, counter and output registers stay in `token_scheduler`.

## Test plan
- R=2, all lanes enabled, `a`=1111_1111 → passes on tokens 2, 4, 6, 8. `b` one cycle after each, lanes 0,1,2,3 in turn.
- R=1, `lane_en`=4'b0101, `a`=1 for 4 cycles → `b` sequence 0001, 0100, 0001, 0100. `drop` stays 0.
- R=3, `lane_en`=0, 6 tokens → `drop` pulses one cycle after tokens 3 and 6. `b` stays 0. With stats: `drop_cnt`=2.
- Accept with `a`=1 in RUN at R=2, counter=1 → that token passes (old R). LOAD cycle token ignored. New R counts from 0 two cycles after the accept.
- Assert `rst` asynchronously between clock edges while `b`≠0 → `b`=0, `cfg_ready`=1 immediately. Tokens are ignored until a new config has been accepted.
- R=0 with a continuous `a`=1 stream → `b`=0 and `drop`=0 throughout. `cfg_ready` stays 1.

Source files
------------

// File: rtl/token_scheduler_pkg.sv
// Shared types and constants for the token scheduler.
// Contents: scheduler state enum, stats counter width, mute ratio code,
// and a saturating-increment helper for the optional stats counters.
package token_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } sched_state_t;

  localparam int unsigned STATS_W    = 16;
  localparam int unsigned RATIO_MUTE = 0;

  // Saturating increment for statistics counters
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/token_scheduler_if.sv
// Token/config bus between a token source (master) and token_scheduler (slave).
// Signals: a (serial token), cfg_valid/cfg_ratio/cfg_ready (ratio handshake),
// lane_en (lane enables), b (one-hot lane output), drop (no-lane pulse).
// With TOKEN_SCHEDULER_STATS_EN: pass_cnt, drop_cnt statistics outputs.
interface token_scheduler_if
  import token_sched_pkg::*;
#(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned RATIO_W = 4
);
  logic               a;
  logic               cfg_valid;
  logic [RATIO_W-1:0] cfg_ratio;
  logic               cfg_ready;
  logic [N_LANES-1:0] lane_en;
  logic [N_LANES-1:0] b;
  logic               drop;
`ifdef TOKEN_SCHEDULER_STATS_EN
  logic [STATS_W-1:0] pass_cnt;
  logic [STATS_W-1:0] drop_cnt;
`endif

  modport master (
    output a, cfg_valid, cfg_ratio, lane_en,
`ifdef TOKEN_SCHEDULER_STATS_EN
    input  pass_cnt, drop_cnt,
`endif
    input  cfg_ready, b, drop
  );

  modport slave (
    input  a, cfg_valid, cfg_ratio, lane_en,
`ifdef TOKEN_SCHEDULER_STATS_EN
    output pass_cnt, drop_cnt,
`endif
    output cfg_ready, b, drop
  );

endinterface

// File: rtl/token_rr_select.sv
// Combinational round-robin lane picker.
// Ports: last (index of most recent grant), lane_en (lane enables),
// grant (one-hot first enabled lane after last, wrapping), none (no lane enabled).
module token_rr_select #(
  parameter int unsigned N_LANES = 4,
  localparam int unsigned LAST_W = $clog2(N_LANES)
) (
  input  logic [LAST_W-1:0]  last,
  input  logic [N_LANES-1:0] lane_en,
  output logic [N_LANES-1:0] grant,
  output logic               none
);

  logic        found;
  int unsigned idx;

  // Scan last+1 .. last+N_LANES (mod N_LANES); the last step revisits 'last' itself
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= N_LANES; i++) begin
      idx = (int'(last) + i) % N_LANES;
      if (!found && lane_en[LAST_W'(idx)]) begin
        grant[LAST_W'(idx)] = 1'b1;
        found               = 1'b1;
      end
    end
    none = !found;
  end

endmodule

// File: rtl/token_scheduler.sv
// Serial token scheduler: passes every R-th token on bus.a and deals passed
// tokens round-robin to enabled lanes on bus.b (registered), pulsing bus.drop
// when no lane is enabled. R is loaded via cfg_valid/cfg_ready.
// Ports: clk, rst (async active-high), bus (token_scheduler_if.slave).
// Optional macro TOKEN_SCHEDULER_STATS_EN adds pass_cnt/drop_cnt outputs.
module token_scheduler
  import token_sched_pkg::*;
#(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned RATIO_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  token_scheduler_if.slave  bus
);

  localparam int unsigned LAST_W = $clog2(N_LANES);

  sched_state_t       state_q, state_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic [LAST_W-1:0]  last_q, last_d;
  logic [N_LANES-1:0] b_q, b_d;
  logic               drop_q, drop_d;

  logic [N_LANES-1:0] grant;
  logic               none;
  logic [LAST_W-1:0]  grant_idx;
  logic               accept;

  token_rr_select #(.N_LANES(N_LANES)) u_rr (
    .last    (last_q),
    .lane_en (bus.lane_en),
    .grant   (grant),
    .none    (none)
  );

  // Ready is a pure state decode so it never depends on cfg_valid
  assign bus.cfg_ready = (state_q != LOAD);
  assign accept        = bus.cfg_valid & bus.cfg_ready;

  // One-hot grant to lane index
  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (grant[i]) grant_idx = LAST_W'(i);
    end
  end

  // Next-state, counter and scheduling decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    last_d  = last_q;
    b_d     = '0;
    drop_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          ratio_d = bus.cfg_ratio;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // Token uses the ratio in force this cycle, even if a new one is accepted
        if (bus.a && (ratio_q != RATIO_W'(RATIO_MUTE))) begin
          if (cnt_q == ratio_q - RATIO_W'(1)) begin
            cnt_d = '0;
            if (none) begin
              drop_d = 1'b1;
            end else begin
              b_d    = grant;
              last_d = grant_idx;
            end
          end else begin
            cnt_d = cnt_q + RATIO_W'(1);
          end
        end
        if (accept) begin
          state_d = LOAD;
          ratio_d = bus.cfg_ratio;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ratio_q <= '0;
      last_q  <= LAST_W'(N_LANES - 1);
      b_q     <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      last_q  <= last_d;
      b_q     <= b_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.b    = b_q;
  assign bus.drop = drop_q;

`ifdef TOKEN_SCHEDULER_STATS_EN
  logic [STATS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [STATS_W-1:0] drop_cnt_q, drop_cnt_d;

  // Counters advance on the same edge that raises b/drop; LOAD clears them
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (state_q == LOAD) begin
      pass_cnt_d = '0;
      drop_cnt_d = '0;
    end else begin
      if (|b_d)  pass_cnt_d = sat_inc(pass_cnt_q);
      if (drop_d) drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.pass_cnt = pass_cnt_q;
  assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule
